// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Latches decoded operands and control from decode. Drives the ALU operands and
// op select, the forwarded store data, and a load-use stall request to decode.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   stall, flush                   hold / bubble controls for the EX slot
//   id_*                           decoded instruction fields from decode
//   exmem_*, memwb_*               forwarding sources from later stages
//   alu_a, alu_b, alu_control      ALU operand and op-select drive
//   ex_store_data                  forwarded rs2 value for stores
//   ex_valid, ex_reg_write,
//   ex_mem_read, ex_mem_write,
//   ex_rd                          registered control for downstream stages
//   load_use_stall                 combinational stall request to IF/ID
module id_ex_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [2:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_data,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [2:0]       alu_control,
    output logic [XLEN-1:0]  ex_store_data,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [RADDR-1:0] ex_rd,
    output logic             load_use_stall
);

    logic [RADDR-1:0] rs1_q;
    logic [RADDR-1:0] rs2_q;
    logic [XLEN-1:0]  rs1_data_q;
    logic [XLEN-1:0]  rs2_data_q;
    logic [XLEN-1:0]  imm_q;
    logic             alu_src_q;
    logic [XLEN-1:0]  fwd_rs1;
    logic [XLEN-1:0]  fwd_rs2;
    logic             bubble;

    // Load in EX whose destination is read by the instruction in decode.
    assign load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                            ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Flush always bubbles; a load-use bubble only applies when not stalled.
    assign bubble = flush | (~stall & load_use_stall);

    // Pipeline register: bubbles clear only the control bits, data is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rd        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            alu_control  <= 3'b000;
            alu_src_q    <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid & id_reg_write;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_mem_write <= id_valid & id_mem_write;
            ex_rd        <= id_rd;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            alu_control  <= id_alu_control;
            alu_src_q    <= id_alu_src;
        end
    end

    // Forwarding muxes; EX/MEM is the younger result so it wins over MEM/WB.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
            fwd_rs1 = memwb_data;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
            fwd_rs2 = memwb_data;
        end
    end

    assign alu_a         = fwd_rs1;
    assign alu_b         = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule
